truth_table_prober: RTL and testbench
=====================================

Name: truth_table_prober

Overview:
- Sequential driver and sampler for a 2-input, 1-output combinational function block (inputs x, y; output z).
- On each start, drives all four (x, y) combinations in order, waits a programmable settle time, and samples z for each combination.
- Assembles a 4-bit truth table and compares it against an expected function.
- Sits on the input side of a combinational function block as its stimulus source and result reader; used for self-test and bring-up.

Parameters:
- SETTLE_CYCLES, 1, cycles x_out/y_out are held stable before z_in is sampled; legal range 1..255.
- EXPECTED, 4'b1101, expected truth table; bit index = {x,y}.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; accepted only in IDLE.
- abort  input  1  cancel an in-progress sweep.
- z_in  input  1  output of the function block under probe.
- x_out  output  1  x stimulus to the block.
- y_out  output  1  y stimulus to the block.
- busy  output  1  high while a sweep is in progress (SETTLE/SAMPLE).
- done  output  1  one-cycle pulse when a sweep completes.
- result_valid  output  1  truth_table/match/mismatch_mask hold a completed sweep.
- truth_table  output  4  captured z; bit {x,y}.
- match  output  1  truth_table == EXPECTED.
- mismatch_mask  output  4  truth_table XOR EXPECTED.

Behaviour:
- Reset value of every output is 0. Internal state: IDLE, idx=0, cnt=0, shadow=0.
- States:
  - IDLE: x_out=y_out=0, busy=0.
    - start=1 -> SETTLE, idx=0, cnt=0, result_valid cleared.
  - SETTLE: {x_out,y_out}=idx, busy=1.
    - cnt increments each cycle.
    - When cnt==SETTLE_CYCLES-1 -> SAMPLE.
  - SAMPLE: {x_out,y_out}=idx held, busy=1.
    - shadow[idx] <= z_in.
    - idx==3 -> DONE.
    - Otherwise idx++, cnt=0 -> SETTLE.
  - DONE (one cycle): busy=0, done=1, x_out=y_out=0.
    - truth_table, match, mismatch_mask and result_valid=1 are registered from shadow (including the final sample).
    - Next state: IDLE.
- Latency: DONE is the (4*(SETTLE_CYCLES+1)+1)-th cycle after the start edge. For SETTLE_CYCLES=1 this is 9 cycles.
- The sample for combination k is taken in the cycle that is (k+1)*(SETTLE_CYCLES+1) cycles after the start edge.
- Results are published only in DONE. Published outputs hold their value until the next accepted start (which clears result_valid only) or reset.
- start while not in IDLE (including DONE) is ignored; there is no queuing.
- abort in SETTLE or SAMPLE -> IDLE next cycle:
  - no done pulse, no sample taken that cycle;
  - shadow discarded;
  - result_valid stays 0.
- abort in IDLE or DONE has no effect.
- start and abort high together in IDLE: start wins (abort only applies to an active sweep).
- reset takes priority over everything, including mid-sweep and in DONE; all outputs 0 the following cycle.
- z_in is sampled only in SAMPLE; its value in every other state is don't-care.
- cnt width is 8 bits; it never wraps because it is cleared at SETTLE_CYCLES-1.
- idx is 2 bits and stops at 3; no wrap-around occurs.

Decomposition:
- Shared package truth_probe_pkg:
  - state enum {IDLE, SETTLE, SAMPLE, DONE};
  - NUM_COMBOS=4;
  - IDX_W=2;
  - CNT_W=8.
- One sub-module: settle_timer (clear, enable, terminal-count compare against SETTLE_CYCLES-1; output expired). The FSM, shadow register and comparator stay in truth_table_prober.

Test Plan:
- Golden function: model z=(x&~y)|(x~^y), SETTLE_CYCLES=1, pulse start -> done on the 9th cycle after the start edge; truth_table=4'b1101, match=1, mismatch_mask=0, result_valid=1.
- Faulty function: model z=x&y -> truth_table=4'b1000, match=0, mismatch_mask=4'b0101.
- Stimulus ordering: SETTLE_CYCLES=3, monitor outputs -> {x_out,y_out} steps 00,01,10,11, each held 4 cycles; done on the 17th cycle after the start edge; busy high for exactly 16 cycles.
- Abort: assert abort during the idx=2 SETTLE -> IDLE next cycle, no done pulse, result_valid=0, x_out=y_out=0. A subsequent start completes normally with a correct table.
- Ignored start: pulse start again during SETTLE and in DONE -> no restart and no second done; earlier results unchanged until a start is accepted in IDLE.
- Reset: assert reset in SAMPLE with idx=1 -> all outputs 0 the next cycle. Hold reset high together with start -> stays in IDLE.

Source files
------------

// File: rtl/truth_probe_pkg.sv
// Shared types and widths for the truth-table prober and its settle timer.
package truth_probe_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_e;

   localparam int unsigned NUM_COMBOS = 4;
   localparam int unsigned IDX_W      = 2;
   localparam int unsigned CNT_W      = 8;

endpackage

// File: rtl/truth_table_prober_settle_timer.sv
// Settle-time counter: counts enabled cycles and flags the last settle cycle.
module settle_timer
   import truth_probe_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(SETTLE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == TERMINAL);

endmodule

// File: rtl/truth_table_prober.sv
// Drives all four (x,y) combinations into a 2-input block, samples z after a
// settle delay, and publishes the captured truth table against EXPECTED.
module truth_table_prober
   import truth_probe_pkg::*;
#(
   parameter int unsigned            SETTLE_CYCLES = 1,
   parameter logic [NUM_COMBOS-1:0]  EXPECTED      = 4'b1101
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  z_in,
   output logic                  x_out,
   output logic                  y_out,
   output logic                  busy,
   output logic                  done,
   output logic                  result_valid,
   output logic [NUM_COMBOS-1:0] truth_table,
   output logic                  match,
   output logic [NUM_COMBOS-1:0] mismatch_mask
);

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NUM_COMBOS-1:0] shadow_q, shadow_d;
   logic [NUM_COMBOS-1:0] tt_q, tt_d;
   logic [NUM_COMBOS-1:0] mm_q, mm_d;
   logic                  match_q, match_d;
   logic                  valid_q, valid_d;
   logic                  x_q, x_d;
   logic                  y_q, y_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  timer_clear;
   logic                  timer_expired;
   logic                  active_d;

   settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (timer_clear),
      .enable (state_q == SETTLE),
      .expired(timer_expired)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      tt_d        = tt_q;
      mm_d        = mm_q;
      match_d     = match_q;
      valid_d     = valid_q;
      timer_clear = 1'b1;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETTLE;
               idx_d   = '0;
               valid_d = 1'b0;
            end
         end
         SETTLE: begin
            if (abort) begin
               state_d  = IDLE;
               idx_d    = '0;
               shadow_d = '0;
            end else begin
               timer_clear = timer_expired;
               if (timer_expired) begin
                  state_d = SAMPLE;
               end
            end
         end
         SAMPLE: begin
            if (abort) begin
               state_d  = IDLE;
               idx_d    = '0;
               shadow_d = '0;
            end else begin
               shadow_d[idx_q] = z_in;
               // Publish from shadow_d so the final sample lands in the DONE-cycle outputs.
               if (idx_q == IDX_W'(NUM_COMBOS - 1)) begin
                  state_d = DONE;
                  tt_d    = shadow_d;
                  mm_d    = shadow_d ^ EXPECTED;
                  match_d = (shadow_d == EXPECTED);
                  valid_d = 1'b1;
               end else begin
                  state_d = SETTLE;
                  idx_d   = idx_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d  = IDLE;
            idx_d    = '0;
            shadow_d = '0;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from next-state so they align with the state they describe.
      active_d = (state_d == SETTLE) || (state_d == SAMPLE);
      x_d      = active_d & idx_d[1];
      y_d      = active_d & idx_d[0];
      busy_d   = active_d;
      done_d   = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         shadow_q <= '0;
         tt_q     <= '0;
         mm_q     <= '0;
         match_q  <= 1'b0;
         valid_q  <= 1'b0;
         x_q      <= 1'b0;
         y_q      <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         tt_q     <= tt_d;
         mm_q     <= mm_d;
         match_q  <= match_d;
         valid_q  <= valid_d;
         x_q      <= x_d;
         y_q      <= y_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign x_out         = x_q;
   assign y_out         = y_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign result_valid  = valid_q;
   assign truth_table   = tt_q;
   assign match         = match_q;
   assign mismatch_mask = mm_q;

endmodule

// File: tb/tb_truth_table_prober.sv
// Bench for truth_table_prober: two instances (settle 1 and 3) probing modelled function blocks.
module tb_truth_table_prober;

   localparam logic [3:0] GOLD = 4'b1101;

   logic       clk = 1'b0;
   logic       reset;
   logic       start   [2];
   logic       abort   [2];
   logic       z_in    [2];
   logic       x_out   [2];
   logic       y_out   [2];
   logic       busy    [2];
   logic       done    [2];
   logic       rv      [2];
   logic [3:0] tt      [2];
   logic       match   [2];
   logic [3:0] mm      [2];
   logic [3:0] func_tt [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Function blocks under probe, described as lookup tables indexed by {x,y}.
   assign z_in[0] = func_tt[0][{x_out[0], y_out[0]}];
   assign z_in[1] = func_tt[1][{x_out[1], y_out[1]}];

   truth_table_prober #(
      .SETTLE_CYCLES(1)
   ) dut_s1 (
      .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]), .z_in(z_in[0]),
      .x_out(x_out[0]), .y_out(y_out[0]), .busy(busy[0]), .done(done[0]),
      .result_valid(rv[0]), .truth_table(tt[0]), .match(match[0]), .mismatch_mask(mm[0])
   );

   truth_table_prober #(
      .SETTLE_CYCLES(3)
   ) dut_s3 (
      .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]), .z_in(z_in[1]),
      .x_out(x_out[1]), .y_out(y_out[1]), .busy(busy[1]), .done(done[1]),
      .result_valid(rv[1]), .truth_table(tt[1]), .match(match[1]), .mismatch_mask(mm[1])
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] all_outs(input int d);
      return {x_out[d], y_out[d], busy[d], done[d], rv[d], tt[d], match[d], mm[d]};
   endfunction

   function automatic logic [3:0] table_of(input int which);
      logic [3:0] t;
      for (int v = 0; v < 4; v++) begin
         logic x, y;
         x = v[1];
         y = v[0];
         t[v] = (which == 0) ? ((x & ~y) | (x ~^ y)) : (x & y);
      end
      return t;
   endfunction

   // One sweep on instance d with function f; abort_at>0 aborts in that cycle after the start edge.
   task automatic sweep(input int d, input logic [3:0] f, input int abort_at, input bit poke);
      int s;
      int lat;
      int k;
      s   = (d == 0) ? 1 : 3;
      lat = 4 * (s + 1) + 1;
      func_tt[d] = f;
      start[d] = 1'b1;
      tick();
      for (int c = 1; c <= lat; c++) begin
         if (c > 1) tick();
         start[d] = 1'b0;
         if (c < lat) begin
            k = (c - 1) / (s + 1);
            chk($sformatf("d%0d_c%0d_busy", d, c), 32'(busy[d]), 1);
            chk($sformatf("d%0d_c%0d_done", d, c), 32'(done[d]), 0);
            chk($sformatf("d%0d_c%0d_xy", d, c), 32'({x_out[d], y_out[d]}), 32'(k));
            chk($sformatf("d%0d_c%0d_rv", d, c), 32'(rv[d]), 0);
         end else begin
            chk($sformatf("d%0d_done_pulse", d), 32'(done[d]), 1);
            chk($sformatf("d%0d_done_busy", d), 32'(busy[d]), 0);
            chk($sformatf("d%0d_done_xy", d), 32'({x_out[d], y_out[d]}), 0);
            chk($sformatf("d%0d_tt", d), 32'(tt[d]), 32'(f));
            chk($sformatf("d%0d_match", d), 32'(match[d]), 32'(f == GOLD));
            chk($sformatf("d%0d_mm", d), 32'(mm[d]), 32'(f ^ GOLD));
            chk($sformatf("d%0d_rv", d), 32'(rv[d]), 1);
         end
         if (c == abort_at) begin
            abort[d] = 1'b1;
            tick();
            abort[d] = 1'b0;
            chk($sformatf("d%0d_abort_busy", d), 32'(busy[d]), 0);
            chk($sformatf("d%0d_abort_xy", d), 32'({x_out[d], y_out[d]}), 0);
            chk($sformatf("d%0d_abort_rv", d), 32'(rv[d]), 0);
            for (int w = 0; w < lat; w++) begin
               chk($sformatf("d%0d_abort_nodone", d), 32'({done[d], busy[d]}), 0);
               tick();
            end
            return;
         end
         if (poke && (c == 1 || c == lat)) start[d] = 1'b1;
      end
      tick();
      start[d] = 1'b0;
      chk($sformatf("d%0d_post_idle", d), 32'({busy[d], done[d], x_out[d], y_out[d]}), 0);
      chk($sformatf("d%0d_post_hold", d), 32'({rv[d], tt[d], match[d], mm[d]}),
          32'({1'b1, f, f == GOLD, f ^ GOLD}));
      if (poke) begin
         tick();
         chk($sformatf("d%0d_no_restart", d), 32'({busy[d], done[d], rv[d], tt[d]}), 32'({3'b001, f}));
      end
   endtask

   initial begin
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         start[d] = 1'b0;
         abort[d] = 1'b0;
         func_tt[d] = 4'b0000;
      end
      repeat (3) tick();
      chk("reset_s1", 32'(all_outs(0)), 0);
      chk("reset_s3", 32'(all_outs(1)), 0);
      reset = 1'b0;
      tick();

      sweep(0, table_of(0), -1, 1'b0);        // golden, latency 9
      sweep(0, table_of(1), -1, 1'b0);        // x&y -> 1000, mask 0101
      sweep(1, table_of(0), -1, 1'b0);        // settle 3, latency 17, busy 16
      sweep(1, table_of(0), 4 * 2 + 1, 1'b0); // abort in idx=2 SETTLE
      sweep(1, table_of(0), -1, 1'b0);        // recovers after abort
      sweep(0, table_of(0), 2 * 2 + 1, 1'b0); // abort in idx=2 SETTLE, settle 1
      sweep(0, table_of(1), -1, 1'b1);        // starts during SETTLE and DONE ignored

      for (int i = 0; i < 8; i++) begin
         int d;
         int lat;
         int ab;
         d   = i % 2;
         lat = (d == 0) ? 9 : 17;
         ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, lat - 1)) : -1;
         sweep(d, 4'($urandom), ab, 1'($urandom_range(0, 1)));
      end

      // Reset during SAMPLE with idx=1 (cycle 4 for settle 1).
      func_tt[0] = 4'b0110;
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      repeat (3) tick();
      chk("pre_reset_xy", 32'({busy[0], x_out[0], y_out[0]}), 32'(3'b101));
      reset = 1'b1;
      tick();
      chk("mid_reset_s1", 32'(all_outs(0)), 0);
      chk("mid_reset_s3", 32'(all_outs(1)), 0);
      start[0] = 1'b1;
      repeat (2) tick();
      chk("reset_with_start", 32'(all_outs(0)), 0);
      reset = 1'b0;
      start[0] = 1'b0;
      tick();
      chk("after_reset_idle", 32'(all_outs(0)), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
